// File: rtl/mcuspi_cmd_pkg.sv
// mcuspi_pkg: shared constants and types for the MCU SPI command-frame parser.
//   SYNC_BYTE    - frame start marker (not part of the checksum)
//   MAX_LEN_DFLT - default maximum data bytes per frame (buffer depth)
//   state_e      - parser state encoding (3 bits)
package mcuspi_pkg;

  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
  localparam int unsigned MAX_LEN_DFLT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

endpackage

// File: rtl/mcuspi_cmd_if.sv
// mcuspi_cmd_if: byte stream in from the SPI receiver, register-write bus and
// frame status out to the configuration bank.
//   spi_data/spi_vld         - received byte + single-cycle strobe
//   cfg_we/cfg_addr/cfg_wdata - register write port
//   frm_ok/frm_err           - per-frame accept/reject pulses
//   err_cnt                  - saturating error counter
// master: the side feeding bytes and consuming writes; slave: the parser.
interface mcuspi_cmd_if;
  logic [7:0] spi_data;
  logic       spi_vld;
  logic       cfg_we;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       frm_ok;
  logic       frm_err;
  logic [7:0] err_cnt;

  modport master (
    output spi_data, spi_vld,
    input  cfg_we, cfg_addr, cfg_wdata, frm_ok, frm_err, err_cnt
  );

  modport slave (
    input  spi_data, spi_vld,
    output cfg_we, cfg_addr, cfg_wdata, frm_ok, frm_err, err_cnt
  );
endinterface

// File: rtl/mcuspi_cmd_gapwd.sv
// mcuspi_gapwd: inter-byte gap watchdog.
//   clk, rst_n - clock, async active-low reset
//   clr        - zero the counter (has priority over en)
//   en         - count one cycle
//   expired    - counter has reached LIMIT (holds there until cleared)
module mcuspi_gapwd #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

endmodule

// File: rtl/mcuspi_cmd.sv
// mcuspi_cmd: parses SYNC/ADDR/LEN/DATA.../CHK frames from the SPI byte stream
// and, only once the XOR checksum matches, replays the buffered data as
// consecutive register writes at addr, addr+1, ... (8-bit wrap).
//   clk_sys, rst_n - clock, async active-low reset
//   bus (slave)    - byte stream in; cfg write port, frame status, err_cnt out
module mcuspi_cmd
  import mcuspi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned MAX_LEN = MAX_LEN_DFLT
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  mcuspi_cmd_if.slave  bus
);
  localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e                      state_q, state_d;
  logic [7:0]                  addr_q, addr_d;
  logic [IDXW-1:0]             len_m1_q, len_m1_d;  // len-1, so it fits the index width
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [7:0]                  chk_q, chk_d;
  logic [MAX_LEN-1:0][7:0]     buf_q, buf_d;
  logic                        cfg_we_q, cfg_we_d;
  logic [7:0]                  cfg_addr_q, cfg_addr_d;
  logic [7:0]                  cfg_wdata_q, cfg_wdata_d;
  logic                        frm_ok_q, frm_ok_d;
  logic                        frm_err_q, frm_err_d;
  logic [7:0]                  err_cnt_q, err_cnt_d;
  logic                        err_inc;
  logic                        gap_clr, gap_exp;

  wire       vld  = bus.spi_vld;
  wire [7:0] data = bus.spi_data;

  // The watchdog only runs while a frame is half-received.
  assign gap_clr = vld || (state_q == ST_IDLE) || (state_q == ST_COMMIT);

  mcuspi_gapwd #(.LIMIT(TIMEOUT)) u_gapwd (
    .clk     (clk_sys),
    .rst_n   (rst_n),
    .clr     (gap_clr),
    .en      (1'b1),
    .expired (gap_exp)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_m1_d    = len_m1_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    buf_d       = buf_q;
    cfg_we_d    = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    frm_ok_d    = 1'b0;
    frm_err_d   = 1'b0;
    err_inc     = 1'b0;

    unique case (state_q)
      ST_IDLE: if (vld && data == SYNC_BYTE) state_d = ST_ADDR;

      ST_ADDR: if (vld) begin
        addr_d  = data;
        chk_d   = data;
        state_d = ST_LEN;
      end

      ST_LEN: if (vld) begin
        if (data != 8'd0 && data <= 8'(MAX_LEN)) begin
          len_m1_d = IDXW'(data - 8'd1);
          chk_d    = chk_q ^ data;
          idx_d    = '0;
          state_d  = ST_DATA;
        end else begin
          frm_err_d = 1'b1;
          err_inc   = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_DATA: if (vld) begin
        buf_d[idx_q] = data;
        chk_d        = chk_q ^ data;
        if (idx_q == len_m1_q) state_d = ST_CHK;
        else                   idx_d   = idx_q + IDXW'(1);
      end

      // The first write is launched straight from the CHK byte so it lands
      // one cycle after it; COMMIT only handles writes 1..len-1.
      ST_CHK: if (vld) begin
        if (data == chk_q) begin
          cfg_we_d    = 1'b1;
          cfg_addr_d  = addr_q;
          cfg_wdata_d = buf_q[0];
          frm_ok_d    = 1'b1;
          idx_d       = IDXW'(1);
          state_d     = (len_m1_q == '0) ? ST_IDLE : ST_COMMIT;
        end else begin
          frm_err_d = 1'b1;
          err_inc   = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_COMMIT: begin
        cfg_we_d    = 1'b1;
        cfg_addr_d  = addr_q + 8'(idx_q);
        cfg_wdata_d = buf_q[idx_q];
        if (idx_q == len_m1_q) state_d = ST_IDLE;
        else                   idx_d   = idx_q + IDXW'(1);
        // No room to take a new frame while replaying; count the loss.
        if (vld) err_inc = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // Gap timeout; a byte in the same cycle wins, so vld gates it.
    if (gap_exp && !vld &&
        (state_q == ST_ADDR || state_q == ST_LEN ||
         state_q == ST_DATA || state_q == ST_CHK)) begin
      frm_err_d = 1'b1;
      err_inc   = 1'b1;
      state_d   = ST_IDLE;
    end

    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_m1_q    <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      frm_ok_q    <= 1'b0;
      frm_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_m1_q    <= len_m1_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      frm_ok_q    <= frm_ok_d;
      frm_err_q   <= frm_err_d;
      err_cnt_q   <= err_cnt_d;
    end

  // Buffer is only ever read after being written in the same frame.
  always_ff @(posedge clk_sys) buf_q <= buf_d;

  assign bus.cfg_we    = cfg_we_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_wdata = cfg_wdata_q;
  assign bus.frm_ok    = frm_ok_q;
  assign bus.frm_err   = frm_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mcuspi_cmd.sv
// Directed bench for mcuspi_cmd: hand-computed frames, write log and pulse
// counters captured on the falling edge.
module tb_mcuspi_cmd;
  localparam int T = 16;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  mcuspi_cmd_if bus();

  mcuspi_cmd #(.TIMEOUT(T), .MAX_LEN(4)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, vld_cyc = 0, err_cyc = 0;
  int n_ok = 0, n_err = 0;
  int w0, o0, e0;
  logic [7:0] wa[$], wd[$];
  int         wc[$];
  logic       wo[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (bus.cfg_we) begin
      wa.push_back(bus.cfg_addr);
      wd.push_back(bus.cfg_wdata);
      wc.push_back(cyc);
      wo.push_back(bus.frm_ok);
    end
    if (bus.frm_ok) n_ok++;
    if (bus.frm_err) begin n_err++; err_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int i, input logic [7:0] a, input logic [7:0] d);
    if (i < wa.size()) begin
      chk({tag, "_addr"}, wa[i], a);
      chk({tag, "_data"}, wd[i], d);
    end else chk({tag, "_missing"}, wa.size(), i + 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_sys); #1;
    bus.spi_data = b;
    bus.spi_vld  = 1'b1;
    vld_cyc      = cyc;
    @(posedge clk_sys); #1;
    bus.spi_vld  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v [8], input int n);
    for (int i = 0; i < n; i++) send_byte(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic mark;
    w0 = wa.size(); o0 = n_ok; e0 = n_err;
  endtask

  initial begin
    bus.spi_data = '0;
    bus.spi_vld  = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_we",    bus.cfg_we,    0);
    chk("rst_addr",  bus.cfg_addr,  0);
    chk("rst_wdata", bus.cfg_wdata, 0);
    chk("rst_ok",    bus.frm_ok,    0);
    chk("rst_err",   bus.frm_err,   0);
    chk("rst_cnt",   bus.err_cnt,   0);
    rst_n = 1'b1;
    idle(2);

    // Good frame: chk = 10^02^11^22 = 21
    mark();
    send_frame('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 8'h0, 8'h0}, 6);
    idle(6);
    chk("t1_nwr", wa.size() - w0, 2);
    check_wr("t1_w0", w0,     8'h10, 8'h11);
    check_wr("t1_w1", w0 + 1, 8'h11, 8'h22);
    if (wa.size() >= w0 + 2) begin
      chk("t1_lat",    wc[w0] - vld_cyc,  1);
      chk("t1_consec", wc[w0+1] - wc[w0], 1);
      chk("t1_ok_w0",  wo[w0],            1);
    end
    chk("t1_nok", n_ok - o0,   1);
    chk("t1_cnt", bus.err_cnt, 0);

    // Bad checksum
    mark();
    send_frame('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20, 8'h0, 8'h0}, 6);
    idle(6);
    chk("t2_nwr",    wa.size() - w0,    0);
    chk("t2_nerr",   n_err - e0,        1);
    chk("t2_errlat", err_cyc - vld_cyc, 1);
    chk("t2_cnt",    bus.err_cnt,       1);

    // Address wrap: chk = FF^02^AA^BB = EC
    mark();
    send_frame('{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC, 8'h0, 8'h0}, 6);
    idle(6);
    chk("t3_nwr", wa.size() - w0, 2);
    check_wr("t3_w0", w0,     8'hFF, 8'hAA);
    check_wr("t3_w1", w0 + 1, 8'h00, 8'hBB);

    // Bad LEN (too long, zero), then a good frame: chk = 30^01^77 = 46
    mark();
    send_frame('{8'hA5, 8'h10, 8'h05, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    idle(2);
    chk("t4_len5_err", n_err - e0, 1);
    send_frame('{8'hA5, 8'h10, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    idle(2);
    chk("t4_len0_err", n_err - e0, 2);
    send_frame('{8'hA5, 8'h30, 8'h01, 8'h77, 8'h46, 8'h0, 8'h0, 8'h0}, 5);
    idle(4);
    chk("t4_nwr", wa.size() - w0, 1);
    check_wr("t4_w0", w0, 8'h30, 8'h77);
    chk("t4_cnt", bus.err_cnt, 3);

    // LEN byte lands exactly when the gap counter hits TIMEOUT: still taken.
    // chk = 10^01^5A = 4B
    mark();
    send_frame('{8'hA5, 8'h10, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2);
    repeat (T - 1) @(posedge clk_sys);
    send_frame('{8'h01, 8'h5A, 8'h4B, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    idle(4);
    chk("t5a_nerr", n_err - e0, 0);
    check_wr("t5a_w0", w0, 8'h10, 8'h5A);

    // Real timeout, then garbage + good frame: chk = 20^01^5A = 7B
    mark();
    send_frame('{8'hA5, 8'h10, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2);
    idle(T + 4);
    chk("t5b_tmo_err", n_err - e0,  1);
    chk("t5b_cnt",     bus.err_cnt, 4);
    send_frame('{8'h33, 8'hA5, 8'h20, 8'h01, 8'h5A, 8'h7B, 8'h0, 8'h0}, 6);
    idle(4);
    chk("t5b_nerr", n_err - e0, 1);
    chk("t5b_nwr",  wa.size() - w0, 1);
    check_wr("t5b_w0", w0, 8'h20, 8'h5A);

    // Byte during COMMIT is dropped and counted; bytes after it are idle
    // garbage (they would form a valid frame if A5 had been taken).
    // chk = 40^04^01^02^03^04 = 40
    mark();
    send_frame('{8'hA5, 8'h40, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h40}, 8);
    send_byte(8'hA5);
    send_frame('{8'h30, 8'h01, 8'h77, 8'h46, 8'h0, 8'h0, 8'h0, 8'h0}, 4);
    idle(6);
    chk("t6_nwr", wa.size() - w0, 4);
    check_wr("t6_w0", w0,     8'h40, 8'h01);
    check_wr("t6_w3", w0 + 3, 8'h43, 8'h04);
    chk("t6_nerr",  n_err - e0,    0);
    chk("t6_cnt",   bus.err_cnt,   5);
    chk("t6_hold_we",   bus.cfg_we,    0);
    chk("t6_hold_addr", bus.cfg_addr,  8'h43);
    chk("t6_hold_data", bus.cfg_wdata, 8'h04);

    // Reset during COMMIT: chk = 50^04^0A^0B^0C^0D = 54
    mark();
    send_frame('{8'hA5, 8'h50, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h54}, 8);
    @(negedge clk_sys);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_we",    bus.cfg_we,    0);
    chk("t7_addr",  bus.cfg_addr,  0);
    chk("t7_wdata", bus.cfg_wdata, 0);
    chk("t7_ok",    bus.frm_ok,    0);
    chk("t7_cnt",   bus.err_cnt,   0);
    idle(3);
    rst_n = 1'b1;
    idle(8);
    chk("t7_nwr", wa.size() - w0, 1);

    // err_cnt saturation
    for (int i = 0; i < 254; i++)
      send_frame('{8'hA5, 8'h10, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    idle(3);
    chk("t8_cnt254", bus.err_cnt, 8'hFE);
    for (int i = 0; i < 2; i++)
      send_frame('{8'hA5, 8'h10, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    idle(3);
    chk("t8_cnt256", bus.err_cnt, 8'hFF);
    send_frame('{8'hA5, 8'h10, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    idle(3);
    chk("t8_sat", bus.err_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
